fracn_feedback_divider: RTL
===========================

Name: fracn_feedback_divider

Overview:
- pclk-domain fractional-N feedback divider. It is the counterpart of the DCO phase sampler: the sampler turns the DCO phase into a word, and this block turns a frequency control word (FCW) back into DCO-derived edges.
- It divides pclk by N = FCW_INT + carry, where carry comes from a first-order accumulator over FCW_FRAC.
- Outputs are div_clk and div_pulse, plus the accumulator residue (frac_err), which loop logic uses for phase-error correction.
- A valid/ready handshake accepts FCW updates only at period boundaries.

Parameters:
- INT_W, 8, width of the integer FCW; the period counter is INT_W+1 bits.
- FRAC_W, 16, width of the fractional FCW and accumulator.
- MIN_DIV, 4, minimum legal integer divide ratio.

Ports:
- pclk  in  1  DCO clock; all logic on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- en  in  1  run enable.
- fcw_int  in  INT_W  integer divide ratio.
- fcw_frac  in  FRAC_W  fractional divide ratio, units of 2^-FRAC_W.
- fcw_valid  in  1  FCW offered.
- fcw_ready  out  1  FCW accepted this cycle when fcw_valid=1.
- div_pulse  out  1  one-cycle pulse in the last pclk cycle of each period.
- div_clk  out  1  divided clock, high for ceil(N/2) cycles and low for floor(N/2) cycles.
- frac_err  out  FRAC_W  accumulator value after the most recent period-start update.
- period_cnt  out  16  number of completed periods; wraps.
- pclk_cnt  out  32  pclk cycles spent in RUN; wraps.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; cnt=0; acc=0.
  - Active FCW: int=MIN_DIV, frac=0.
  - All outputs 0, including fcw_ready.
  - Reset asserted mid-period clears everything immediately; there is no completion pulse.
- Outputs are flops decoded from the next-state values, so they align with cnt in the same cycle.
- States:
  - IDLE: fcw_ready=1; div_clk=0; div_pulse=0; counters hold.
    - Handshake (fcw_valid&&fcw_ready) loads the active FCW.
    - en=1 moves to RUN next cycle; that first RUN cycle is a period start.
  - RUN: cnt counts 0..N-1.
    - Terminal cycle is cnt==N-1: div_pulse=1, fcw_ready=1, period_cnt+1.
    - The next cycle is a period start with cnt=0.
    - pclk_cnt increments every RUN cycle.
    - en=0 in any RUN cycle moves to IDLE next cycle: cnt=0, acc=0, div_clk=0, div_pulse=0. period_cnt, pclk_cnt and frac_err hold.
- Handshake:
  - fcw_ready is high in IDLE and in the RUN terminal cycle only; it is low otherwise.
  - An FCW accepted in a terminal cycle governs the immediately following period, including its carry computation.
  - fcw_valid held across non-ready cycles is not consumed; it is accepted exactly once.
- Clamping at load:
  - fcw_int<MIN_DIV loads int=MIN_DIV and frac=0.
  - Otherwise the word loads unchanged.
- Period computation, done at each period start using the active FCW:
  - {carry, acc} = acc + frac, a FRAC_W+1-bit sum; acc wraps mod 2^FRAC_W.
  - N = int + carry, an INT_W+1-bit value, so int=2^INT_W-1 with carry gives N=2^INT_W.
  - frac_err updates to the new acc.
  - N is held for the whole period.
- div_clk is high while cnt < ceil(N/2), otherwise low.
- Simultaneous events:
  - en falling in the terminal cycle: div_pulse and period_cnt still occur in that cycle, then IDLE.
  - Handshake in the same cycle still loads the FCW.

Test Plan:
- Reset check: resetn=0 with en=1 → all outputs 0 and fcw_ready=0. Release with en=0 → fcw_ready=1, div_clk=0.
- Integer divide: load int=10, frac=0, then en=1 → div_pulse every 10 cycles; div_clk high 5 / low 5; frac_err=0; period_cnt=5 after 50 cycles.
- Odd ratio: int=7 → div_clk high 4 / low 3; pulse period 7.
- Fractional divide: int=10, frac=0x4000 → period lengths 10,10,10,11 repeating (41 cycles per 4 periods). frac_err sequence is 0x4000, 0x8000, 0xC000, 0x0000.
- Mid-run update: running int=10; hold fcw_valid with int=12 from mid-period → fcw_ready=1 only on the terminal cycle, a single accept, the next period is 12 cycles, and fcw_ready=0 at other RUN cycles.
- Clamp and abort:
  - Load int=2, frac=0x8000 → period 4, frac_err stays 0.
  - Drop en at cnt=2 → IDLE next cycle, cnt=0, acc=0, no pulse.
  - Assert resetn=0 mid-period → immediate clear of all outputs.

Source files
------------

// File: rtl/fracn_feedback_divider.sv
// Fractional-N feedback divider: divides pclk by N = FCW_INT + carry, where carry
// comes from a first-order accumulator over FCW_FRAC. FCW updates are accepted
// through a valid/ready handshake only in IDLE or in the last cycle of a period.
//
// Ports:
//   pclk        in   DCO clock, all logic on posedge
//   resetn      in   asynchronous active-low reset
//   en          in   run enable
//   fcw_int     in   integer divide ratio (INT_W)
//   fcw_frac    in   fractional divide ratio, units of 2^-FRAC_W (FRAC_W)
//   fcw_valid   in   FCW offered
//   fcw_ready   out  FCW accepted this cycle when fcw_valid=1
//   div_pulse   out  one-cycle pulse in the last pclk cycle of each period
//   div_clk     out  divided clock, high ceil(N/2) / low floor(N/2) cycles
//   frac_err    out  accumulator residue after the latest period start (FRAC_W)
//   period_cnt  out  completed periods, wrapping (16)
//   pclk_cnt    out  pclk cycles spent in RUN, wrapping (32)
module fracn_feedback_divider #(
    parameter int unsigned INT_W   = 8,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned MIN_DIV = 4
) (
    input  logic              pclk,
    input  logic              resetn,
    input  logic              en,
    input  logic [INT_W-1:0]  fcw_int,
    input  logic [FRAC_W-1:0] fcw_frac,
    input  logic              fcw_valid,
    output logic              fcw_ready,
    output logic              div_pulse,
    output logic              div_clk,
    output logic [FRAC_W-1:0] frac_err,
    output logic [15:0]       period_cnt,
    output logic [31:0]       pclk_cnt
);

    // Period counter needs one extra bit so int=2^INT_W-1 plus carry fits.
    localparam int unsigned CNT_W = INT_W + 1;
    localparam int unsigned SUM_W = FRAC_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [INT_W-1:0]  fcw_int_q, fcw_int_d;
    logic [FRAC_W-1:0] fcw_frac_q, fcw_frac_d;
    logic              fcw_ready_q, fcw_ready_d;
    logic              div_pulse_q, div_pulse_d;
    logic              div_clk_q, div_clk_d;
    logic [FRAC_W-1:0] frac_err_q, frac_err_d;
    logic [15:0]       period_cnt_q, period_cnt_d;
    logic [31:0]       pclk_cnt_q, pclk_cnt_d;

    logic              handshake;
    logic [INT_W-1:0]  int_ld, int_eff;
    logic [FRAC_W-1:0] frac_ld, frac_eff;
    logic [SUM_W-1:0]  sum;
    logic              terminal;
    logic              start;
    logic              run_d;
    logic              last_d;

    // Next-state and output decode; outputs are derived from the next-state
    // values so the registered outputs line up with cnt_q in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        n_d          = n_q;
        acc_d        = acc_q;
        frac_err_d   = frac_err_q;
        period_cnt_d = period_cnt_q;
        pclk_cnt_d   = pclk_cnt_q;
        start        = 1'b0;

        handshake = fcw_valid && fcw_ready_q;

        // Illegal integer ratios clamp to MIN_DIV with no fractional part.
        if (fcw_int < INT_W'(MIN_DIV)) begin
            int_ld  = INT_W'(MIN_DIV);
            frac_ld = '0;
        end else begin
            int_ld  = fcw_int;
            frac_ld = fcw_frac;
        end

        // A word accepted this cycle already governs a period starting next cycle.
        int_eff    = handshake ? int_ld : fcw_int_q;
        frac_eff   = handshake ? frac_ld : fcw_frac_q;
        fcw_int_d  = int_eff;
        fcw_frac_d = frac_eff;

        terminal = (state_q == RUN) && (cnt_q == (n_q - CNT_W'(1)));
        sum      = SUM_W'(acc_q) + SUM_W'(frac_eff);

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (terminal) begin
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Period start: advance accumulator, carry stretches this period by one.
        if (start) begin
            cnt_d      = '0;
            acc_d      = sum[FRAC_W-1:0];
            n_d        = CNT_W'(int_eff) + CNT_W'(sum[FRAC_W]);
            frac_err_d = sum[FRAC_W-1:0];
        end

        run_d  = (state_d == RUN);
        last_d = run_d && (cnt_d == (n_d - CNT_W'(1)));

        div_pulse_d = last_d;
        fcw_ready_d = !run_d || last_d;
        div_clk_d   = run_d && (cnt_d < ((n_d + CNT_W'(1)) >> 1));

        if (last_d) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
        if (run_d) begin
            pclk_cnt_d = pclk_cnt_q + 32'd1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= CNT_W'(MIN_DIV);
            acc_q        <= '0;
            fcw_int_q    <= INT_W'(MIN_DIV);
            fcw_frac_q   <= '0;
            fcw_ready_q  <= 1'b0;
            div_pulse_q  <= 1'b0;
            div_clk_q    <= 1'b0;
            frac_err_q   <= '0;
            period_cnt_q <= '0;
            pclk_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            fcw_int_q    <= fcw_int_d;
            fcw_frac_q   <= fcw_frac_d;
            fcw_ready_q  <= fcw_ready_d;
            div_pulse_q  <= div_pulse_d;
            div_clk_q    <= div_clk_d;
            frac_err_q   <= frac_err_d;
            period_cnt_q <= period_cnt_d;
            pclk_cnt_q   <= pclk_cnt_d;
        end
    end

    assign fcw_ready  = fcw_ready_q;
    assign div_pulse  = div_pulse_q;
    assign div_clk    = div_clk_q;
    assign frac_err   = frac_err_q;
    assign period_cnt = period_cnt_q;
    assign pclk_cnt   = pclk_cnt_q;

endmodule
